// File: rtl/param_report_tx.sv
// Parameter-report transmitter: sends SOF, X, Y, Z, NAME and an XOR checksum
// as a byte stream so a collector can confirm the parameters this instance received.
module param_report_tx #(
  parameter int                      X          = 3,
  parameter int                      Y          = 2,
  parameter int                      Z          = 1,
  parameter int                      NAME_LEN   = 8,
  parameter logic [NAME_LEN*8-1:0]   NAME       = "DEFAULT",
  parameter bit                      AUTO_START = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_last,
  output logic       o_busy,
  output logic [7:0] o_frame_cnt
);

  // state  | meaning
  // IDLE   | no frame in progress, waiting for start or auto-start
  // HDR    | presenting SOF byte
  // BODY   | presenting X, Y, Z and NAME bytes, r_idx selects the byte
  // CSUM   | presenting checksum byte with out_last
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_CSUM} state_t;

  localparam int                          BODY_BYTES = 12 + NAME_LEN;
  localparam int                          IW         = $clog2(BODY_BYTES);
  localparam logic [IW-1:0]               LAST_IDX   = IW'(BODY_BYTES - 1);
  localparam logic [7:0]                  SOF        = 8'hA5;
  localparam logic [BODY_BYTES*8-1:0]     BODY_VEC   = {32'(X), 32'(Y), 32'(Z), NAME};

  state_t        r_state;
  state_t        w_state_nx;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_csum;
  logic [7:0]    r_frame_cnt;
  logic          r_auto_pend;
  logic          w_go;
  logic          w_hs;
  logic [7:0]    w_body [BODY_BYTES];

  // Body bytes in transmit order: most significant byte of the packed vector first.
  for (genvar g = 0; g < BODY_BYTES; g++) begin : g_body
    assign w_body[g] = BODY_VEC[(BODY_BYTES-1-g)*8 +: 8];
  end

  assign w_go        = i_start | r_auto_pend;
  assign w_hs        = o_out_valid & i_out_ready;
  assign o_frame_cnt = r_frame_cnt;

  always_comb begin
    w_state_nx  = r_state;
    o_out_valid = 1'b0;
    o_out_data  = 8'h00;
    o_out_last  = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_nx = S_HDR;
      end
      S_HDR: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_data  = SOF;
        if (i_out_ready) w_state_nx = S_BODY;
      end
      S_BODY: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_data  = w_body[r_idx];
        if (i_out_ready && (r_idx == LAST_IDX)) w_state_nx = S_CSUM;
      end
      S_CSUM: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_data  = r_csum;
        o_out_last  = 1'b1;
        if (i_out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_csum      <= 8'h00;
      r_frame_cnt <= 8'h00;
      r_auto_pend <= AUTO_START;
    end else begin
      r_state     <= w_state_nx;
      // Only the first cycle after reset release can see the pending auto-start.
      r_auto_pend <= 1'b0;
      if ((r_state == S_IDLE) && w_go) begin
        r_csum <= 8'h00;
        r_idx  <= '0;
      end else if (w_hs && (r_state != S_CSUM)) begin
        r_csum <= r_csum ^ o_out_data;
      end
      if (w_hs && (r_state == S_BODY)) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_hs && (r_state == S_CSUM)) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_param_report_tx.sv
// Scoreboard bench for param_report_tx: two instances, frames predicted from
// parameter values and compared byte by byte by a negedge monitor.
module tb_param_report_tx;

  localparam int NL = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, ready, valid, last, busy, rdy_mode;
  logic [7:0] data [2];
  logic [7:0] cnt  [2];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q [2][$];
  int         frames_seen    [2] = '{0, 0};
  int         bytes_in_frame [2] = '{0, 0};
  logic [7:0] last_byte      [2] = '{8'h00, 8'h00};
  logic       stall_pend     [2] = '{1'b0, 1'b0};
  logic [8:0] held           [2] = '{9'h000, 9'h000};

  param_report_tx #(.X(3), .Y(2), .Z(1), .NAME_LEN(NL), .NAME("dut1"), .AUTO_START(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .o_out_valid(valid[0]),
    .i_out_ready(ready[0]), .o_out_data(data[0]), .o_out_last(last[0]),
    .o_busy(busy[0]), .o_frame_cnt(cnt[0]));

  param_report_tx #(.X(100), .Y(2), .Z(1), .NAME_LEN(NL), .NAME("dut2"), .AUTO_START(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .o_out_valid(valid[1]),
    .i_out_ready(ready[1]), .o_out_data(data[1]), .o_out_last(last[1]),
    .o_busy(busy[1]), .o_frame_cnt(cnt[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference frame: SOF, each value big-endian, NAME right-aligned with zero fill, XOR of all.
  function automatic void push_frame(input int g, input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z, input string nm);
    logic [7:0]  bytes [$];
    logic [31:0] v [3];
    logic [7:0]  cs;
    int          p;
    v = '{x, y, z};
    bytes.push_back(8'hA5);
    for (int i = 0; i < 3; i++)
      for (int s = 3; s >= 0; s--) bytes.push_back(v[i][8*s +: 8]);
    for (int k = 0; k < NL; k++) begin
      p = k - (NL - nm.len());
      bytes.push_back(p < 0 ? 8'h00 : nm[p]);
    end
    cs = 8'h00;
    foreach (bytes[i]) begin
      cs ^= bytes[i];
      exp_q[g].push_back({1'b0, bytes[i]});
    end
    exp_q[g].push_back({1'b1, cs});
  endfunction

  task automatic wait_frames(input int g, input int target, input int bound, input string nm);
    int k = 0;
    while (frames_seen[g] < target && k < bound) begin
      @(posedge clk);
      k++;
    end
    #2;
    check(nm, frames_seen[g], target);
  endtask

  task automatic wait_bytes(input int g, input int n, input int bound, input string nm);
    int k = 0;
    while (bytes_in_frame[g] != n && k < bound) begin
      @(posedge clk);
      k++;
    end
    #2;
    check(nm, bytes_in_frame[g], n);
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(posedge clk); #2;
    start[g] = 1'b0;
  endtask

  initial begin
    ready = 2'b11;
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) ready[g] = rdy_mode[g] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        stall_pend[g]     = 1'b0;
        bytes_in_frame[g] = 0;
      end else begin
        if (stall_pend[g]) begin
          check("stall_valid_held", 32'(valid[g]), 1);
          check("stall_data_held", {last[g], data[g]}, held[g]);
        end
        if (valid[g] && ready[g]) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte dut%0d: got %0h expected no byte", g, {last[g], data[g]});
          end else begin
            check("stream_byte", {last[g], data[g]}, exp_q[g].pop_front());
          end
          if (last[g]) begin
            last_byte[g] = data[g];
            frames_seen[g]++;
            bytes_in_frame[g] = 0;
          end else begin
            bytes_in_frame[g]++;
          end
        end
        stall_pend[g] = valid[g] && !ready[g];
        held[g]       = {last[g], data[g]};
      end
    end
  end

  initial begin
    int nb;
    int found;
    int base;
    rst = 2'b11; start = 2'b00; rdy_mode = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      check("rst_valid", 32'(valid[g]), 0);
      check("rst_data", data[g], 0);
      check("rst_last", 32'(last[g]), 0);
      check("rst_busy", 32'(busy[g]), 0);
      check("rst_cnt", cnt[g], 0);
    end

    // Auto-start frame on instance A after reset release.
    push_frame(0, 3, 2, 1, "dut1");
    rst = 2'b00;
    wait_frames(0, 1, 60, "auto_frame_done");
    check("auto_cnt", cnt[0], 1);
    check("auto_csum", last_byte[0], 8'hF1);
    @(posedge clk); #2;
    check("b_no_autostart", 32'(valid[1]), 0);

    // Start-pulse frame on instance B: latency, busy length, checksum.
    push_frame(1, 100, 2, 1, "dut2");
    pulse_start(1);
    check("first_byte_valid", 32'(valid[1]), 1);
    check("first_byte_sof", data[1], 8'hA5);
    nb = 0;
    while (busy[1] && nb < 100) begin
      nb++;
      @(posedge clk); #2;
    end
    check("busy_cycles", nb, 18);
    check("b_csum", last_byte[1], 8'h95);
    check("b_cnt", cnt[1], 1);

    // Random backpressure on A.
    rdy_mode[0] = 1'b1;
    @(posedge clk); #2;
    push_frame(0, 3, 2, 1, "dut1");
    pulse_start(0);
    wait_frames(0, 2, 1000, "stall_frame_done");
    rdy_mode[0] = 1'b0;
    check("stall_cnt", cnt[0], 2);

    // Starts during a frame and on the checksum handshake are ignored.
    repeat (2) @(posedge clk);
    #2;
    push_frame(0, 3, 2, 1, "dut1");
    pulse_start(0);
    wait_bytes(0, 5, 100, "reach_byte5");
    pulse_start(0);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (valid[0] && last[0]) begin
        found = 1;
        break;
      end
      @(posedge clk); #2;
    end
    check("csum_cycle_seen", found, 1);
    pulse_start(0);
    repeat (30) @(posedge clk);
    #2;
    check("ignored_start_cnt", cnt[0], 3);
    check("ignored_start_frames", frames_seen[0], 3);
    check("ignored_start_busy", 32'(busy[0]), 0);
    check("a_queue_empty", exp_q[0].size(), 0);

    // Reset in the middle of a B frame.
    push_frame(1, 100, 2, 1, "dut2");
    pulse_start(1);
    wait_bytes(1, 9, 100, "reach_byte9");
    rst[1] = 1'b1;
    #1;
    check("midrst_valid", 32'(valid[1]), 0);
    check("midrst_busy", 32'(busy[1]), 0);
    check("midrst_last", 32'(last[1]), 0);
    check("midrst_data", data[1], 0);
    check("midrst_cnt", cnt[1], 0);
    exp_q[1].delete();
    repeat (2) @(posedge clk);
    #2;
    rst[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midrst_no_restart", 32'(valid[1]), 0);

    // 256 frames, second half with random backpressure; counter must wrap to 0.
    base = frames_seen[1];
    for (int i = 0; i < 256; i++) begin
      rdy_mode[1] = (i >= 128);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #2;
      push_frame(1, 100, 2, 1, "dut2");
      pulse_start(1);
      wait_frames(1, base + i + 1, 300, "burst_frame_done");
      if (i == 0) check("post_rst_cnt", cnt[1], 1);
    end
    rdy_mode[1] = 1'b0;
    check("wrap_cnt", cnt[1], 0);
    check("b_queue_empty", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_report_tx.md
Name: param_report_tx

Overview:
Bindable transmitter that serialises its instance's elaboration parameters (X, Y, Z, NAME) into a checksummed byte frame on a valid/ready stream. It is bound alongside DUT instances so a downstream collector can confirm at run time which parameter values each instance actually received through bind. It is the sending end of the parameter-report channel; the collector is the receiving end.

Parameters:
X, 3, integer reported in frame; low 32 bits transmitted
Y, 2, integer reported in frame; low 32 bits transmitted
Z, 1, integer reported in frame; low 32 bits transmitted
NAME, "DEFAULT", instance label string, packed as NAME_LEN*8 bits
NAME_LEN, 8, number of NAME bytes transmitted (1..32)
AUTO_START, 1, 1 = send one frame automatically after reset release

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to send a frame
out_valid  output  1  byte valid
out_ready  input  1  sink accepts byte
out_data  output  8  frame byte
out_last  output  1  marks checksum byte (final byte of frame)
busy  output  1  frame in progress
frame_cnt  output  8  completed frames, wraps 255->0

Behaviour:
- One clock; reset is asynchronous and active-high. Reset: out_valid=0, out_data=0, out_last=0, busy=0, frame_cnt=0, FSM=IDLE, checksum=0, byte index=0.
- Frame, in order: SOF 0xA5; X[31:0] MSB first (4 B); Y (4 B); Z (4 B); NAME bytes MSB first (NAME_LEN B, string zero-padded on the left as SV packs it); checksum = XOR of all preceding bytes including SOF. Length = 14+NAME_LEN.
- FSM: IDLE -> HDR on start (or first cycle after reset release when AUTO_START=1); HDR -> BODY on SOF handshake; BODY steps byte index on each handshake, -> CSUM after last NAME byte; CSUM -> IDLE on handshake, frame_cnt++.
- Byte transfer occurs on clk edge with out_valid && out_ready. First byte valid one cycle after start sampled. No bubbles: with out_ready held 1, one byte per cycle, frame occupies exactly 14+NAME_LEN cycles.
- While out_valid=1 and out_ready=0: out_data, out_last held stable; out_valid never drops before handshake.
- out_last=1 only with checksum byte.
- busy=1 from cycle after start through cycle of checksum handshake; busy=0 in IDLE.
- start while busy: ignored, not queued. start on same cycle as checksum handshake: ignored.
- AUTO_START fires once per reset release; an external start on that same cycle is merged (one frame).
- Checksum accumulator cleared on entry to HDR; updated on each handshake.
- rst asserted mid-frame: all outputs clear immediately (async); no partial-frame completion, frame_cnt not incremented. Collector must discard partial frames.
- frame_cnt wraps 255 -> 0 with no flag.

Test Plan:
- X=3,Y=2,Z=1,NAME="dut1",NAME_LEN=4,AUTO_START=1, out_ready=1 -> 18 bytes: A5 00 00 00 03 00 00 00 02 00 00 00 01 64 75 74 31 F1, out_last only on F1, frame_cnt=1.
- X=100,NAME="dut2",NAME_LEN=4 via start pulse -> X bytes 00 00 00 64, checksum 0x95, busy high for 18 cycles.
- Random out_ready toggling (~50%) on first case -> identical byte sequence, out_data stable during every stall, no dropped or duplicated bytes.
- start pulsed at byte 5 and on checksum-handshake cycle -> exactly one frame, frame_cnt increments by 1.
- rst asserted at byte 9 then released, AUTO_START=0 -> out_valid=0 immediately, frame_cnt=0, next start yields complete correct frame beginning with A5.
- 256 back-to-back started frames -> frame_cnt returns to 0, every checksum correct.
